telemetry_rx: RTL and testbench

Receive-side counterpart of the `telemetry` transmitter. It deserializes the 8-byte telemetry frame from a UART line. The frame is delimiter 0xAA, 0x55, then batt_v, avg_curr and avg_torque, each as a {4'h0, [11:8]} high byte followed by a [7:0] low byte. The block validates the frame and presents the three 12-bit values atomically with a one-cycle valid strobe. It sits on the bench/host side of the telemetry link, or on a second board that monitors the drive.

---
 rtl/telemetry_pkg.sv | 20 ++
 rtl/UART_rx.sv | 69 ++++++
 rtl/telemetry_rx.sv | 125 ++++++++++++
 tb/tb_telemetry_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry transmitter/receiver pair: frame delimiters,
// payload length and the receive FSM state encoding.
package telemetry_pkg;

    localparam logic [7:0] DELIM1        = 8'hAA;
    localparam logic [7:0] DELIM2        = 8'h55;
    localparam int         PAYLOAD_BYTES = 6;

    typedef enum logic [1:0] {
        SYNC1   = 2'd0,
        SYNC2   = 2'd1,
        PAYLOAD = 2'd2
    } rx_state_t;

    // High payload bytes only carry bits [11:8]; anything in the upper nibble is corrupt.
    function automatic logic hi_nibble_clear(input logic [7:0] b);
        return (b[7:4] == 4'h0);
    endfunction

endpackage

// File: rtl/UART_rx.sv
// 8N1 UART receiver: double-flop synchronizer, mid-bit sampling, rdy held until clr_rdy
// or the next start bit.
module UART_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);

    localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2);
    localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV - 1);

    logic        r_rx1;
    logic        r_rx2;
    logic        r_busy;
    logic        r_rdy;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_baud_cnt;
    logic [7:0]  r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx1 <= 1'b1;
            r_rx2 <= 1'b1;
        end else begin
            r_rx1 <= RX;
            r_rx2 <= r_rx1;
        end
    end

    // Bit 0 is the start bit, 1..8 are data (LSB first), 9 is the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_rdy      <= 1'b0;
            r_bit_cnt  <= 4'd0;
            r_baud_cnt <= 16'd0;
            r_shift    <= 8'h00;
        end else if (!r_busy) begin
            if (!r_rx2) begin
                r_busy     <= 1'b1;
                r_rdy      <= 1'b0;
                r_bit_cnt  <= 4'd0;
                r_baud_cnt <= HALF_BIT;
            end else if (clr_rdy) begin
                r_rdy <= 1'b0;
            end
        end else if (r_baud_cnt != 16'd0) begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
        end else begin
            r_baud_cnt <= FULL_BIT;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd9) begin
                r_busy <= 1'b0;
                r_rdy  <= 1'b1;
            end else if (r_bit_cnt != 4'd0) begin
                r_shift <= {r_rx2, r_shift[7:1]};
            end
        end
    end

    assign rx_data = r_shift;
    assign rdy     = r_rdy;

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry frame receiver: AA 55 then three 12-bit values as hi/lo byte pairs,
// published atomically with a vld strobe; bad or stalled frames pulse frm_err.
//   state   | meaning
//   SYNC1   | hunting for 0xAA
//   SYNC2   | 0xAA seen, expecting 0x55 (further 0xAA keeps us here)
//   PAYLOAD | collecting payload byte idx into the shadow registers
module telemetry_rx
    import telemetry_pkg::*;
#(
    parameter int TIMEOUT  = 100000,
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        vld,
    output logic        frm_err
);

    localparam logic [16:0] TMO      = 17'(TIMEOUT);
    localparam logic [2:0]  LAST_IDX = 3'(PAYLOAD_BYTES - 1);

    logic [7:0]  w_rx_data;
    logic        w_rdy;
    logic        w_clr_rdy;
    logic        w_rst_n;

    rx_state_t   r_state;
    logic [2:0]  r_idx;
    logic [16:0] r_idle;
    logic [3:0]  r_shd_hi [0:2];
    logic [7:0]  r_shd_lo [0:1];
    logic [11:0] r_batt_v;
    logic [11:0] r_avg_curr;
    logic [11:0] r_avg_torque;
    logic        r_vld;
    logic        r_frm_err;

    assign w_rst_n   = ~rst;
    assign w_clr_rdy = w_rdy;

    UART_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_rx (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .RX      (RX),
        .clr_rdy (w_clr_rdy),
        .rx_data (w_rx_data),
        .rdy     (w_rdy)
    );

    // Only the low nibble of high bytes is kept; the last low byte goes straight to the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SYNC1;
            r_idx        <= 3'd0;
            r_idle       <= 17'd0;
            for (int i = 0; i < 3; i++) r_shd_hi[i] <= 4'h0;
            for (int i = 0; i < 2; i++) r_shd_lo[i] <= 8'h00;
            r_batt_v     <= 12'h000;
            r_avg_curr   <= 12'h000;
            r_avg_torque <= 12'h000;
            r_vld        <= 1'b0;
            r_frm_err    <= 1'b0;
        end else begin
            r_vld     <= 1'b0;
            r_frm_err <= 1'b0;
            if (w_rdy) begin
                r_idle <= 17'd0;
                case (r_state)
                    SYNC1: begin
                        if (w_rx_data == DELIM1) r_state <= SYNC2;
                    end
                    SYNC2: begin
                        if (w_rx_data == DELIM2) begin
                            r_state <= PAYLOAD;
                            r_idx   <= 3'd0;
                        end else if (w_rx_data != DELIM1) begin
                            r_state <= SYNC1;
                        end
                    end
                    PAYLOAD: begin
                        if (!r_idx[0] && !hi_nibble_clear(w_rx_data)) begin
                            r_frm_err <= 1'b1;
                            r_state   <= SYNC1;
                            r_idx     <= 3'd0;
                        end else if (r_idx == LAST_IDX) begin
                            r_batt_v     <= {r_shd_hi[0], r_shd_lo[0]};
                            r_avg_curr   <= {r_shd_hi[1], r_shd_lo[1]};
                            r_avg_torque <= {r_shd_hi[2], w_rx_data};
                            r_vld        <= 1'b1;
                            r_state      <= SYNC1;
                            r_idx        <= 3'd0;
                        end else begin
                            if (!r_idx[0]) r_shd_hi[r_idx[2:1]] <= w_rx_data[3:0];
                            else           r_shd_lo[r_idx[1]]   <= w_rx_data;
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                    default: r_state <= SYNC1;
                endcase
            end else if (r_state != SYNC1) begin
                if (r_idle == TMO) begin
                    r_frm_err <= 1'b1;
                    r_state   <= SYNC1;
                    r_idx     <= 3'd0;
                    r_idle    <= 17'd0;
                end else begin
                    r_idle <= r_idle + 17'd1;
                end
            end
        end
    end

    assign batt_v     = r_batt_v;
    assign avg_curr   = r_avg_curr;
    assign avg_torque = r_avg_torque;
    assign vld        = r_vld;
    assign frm_err    = r_frm_err;

endmodule

// File: tb/tb_telemetry_rx.sv
// Serial-stimulus bench for telemetry_rx: a byte-level frame model predicts vld/frm_err
// counts and decoded values; a negedge monitor tracks pulses and output stability.
module tb_telemetry_rx;

    localparam int BAUD = 16;
    localparam int TMO  = 400;

    logic        clk;
    logic        rst;
    logic        RX;
    logic [11:0] batt_v;
    logic [11:0] avg_curr;
    logic [11:0] avg_torque;
    logic        vld;
    logic        frm_err;

    telemetry_rx #(
        .TIMEOUT  (TMO),
        .BAUD_DIV (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .batt_v     (batt_v),
        .avg_curr   (avg_curr),
        .avg_torque (avg_torque),
        .vld        (vld),
        .frm_err    (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor
    int          n_vld = 0, n_err = 0, n_unstable = 0, n_overlap = 0, n_wide = 0;
    logic [11:0] got_b = 0, got_c = 0, got_t = 0;
    logic [35:0] prev_out = 0;
    logic        prev_vld = 0, prev_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_out = {batt_v, avg_curr, avg_torque};
            prev_vld = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (vld) begin
                n_vld++;
                got_b = batt_v; got_c = avg_curr; got_t = avg_torque;
            end else if ({batt_v, avg_curr, avg_torque} != prev_out) begin
                n_unstable++;
            end
            if (frm_err) n_err++;
            if (vld && frm_err) n_overlap++;
            if ((vld && prev_vld) || (frm_err && prev_err)) n_wide++;
            prev_out = {batt_v, avg_curr, avg_torque};
            prev_vld = vld;
            prev_err = frm_err;
        end
    end

    // Reference model: frames found in the byte stream
    int          exp_vld = 0, exp_err = 0;
    logic [11:0] exp_b = 0, exp_c = 0, exp_t = 0;
    logic        m_collect = 0, m_prev_aa = 0;
    logic [7:0]  m_buf[$];

    task automatic model_byte(input logic [7:0] b);
        if (m_collect) begin
            m_buf.push_back(b);
            if ((m_buf.size() % 2 == 1) && (b > 8'h0F)) begin
                exp_err++;
                m_collect = 0;
            end else if (m_buf.size() == 6) begin
                exp_vld++;
                exp_b = 12'(int'(m_buf[0]) * 256 + int'(m_buf[1]));
                exp_c = 12'(int'(m_buf[2]) * 256 + int'(m_buf[3]));
                exp_t = 12'(int'(m_buf[4]) * 256 + int'(m_buf[5]));
                m_collect = 0;
            end
        end else if (m_prev_aa && b == 8'h55) begin
            m_collect = 1;
            m_prev_aa = 0;
            m_buf.delete();
        end else begin
            m_prev_aa = (b == 8'hAA);
        end
    endtask

    task automatic model_stall();
        if (m_collect || m_prev_aa) exp_err++;
        m_collect = 0;
        m_prev_aa = 0;
    endtask

    task automatic model_reset();
        m_collect = 0;
        m_prev_aa = 0;
        exp_b = 0; exp_c = 0; exp_t = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = 1'b1;
        repeat (BAUD) @(negedge clk);
        model_byte(b);
    endtask

    task automatic tx_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        send_byte(8'hAA); send_byte(8'h55);
        send_byte({4'h0, b[11:8]}); send_byte(b[7:0]);
        send_byte({4'h0, c[11:8]}); send_byte(c[7:0]);
        send_byte({4'h0, t[11:8]}); send_byte(t[7:0]);
    endtask

    task automatic stall();
        repeat (TMO + 60) @(negedge clk);
        model_stall();
    endtask

    task automatic settle_check(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_vld_cnt"}, n_vld, exp_vld);
        chk({tag, "_err_cnt"}, n_err, exp_err);
        chk({tag, "_batt"}, batt_v, exp_b);
        chk({tag, "_curr"}, avg_curr, exp_c);
        chk({tag, "_torq"}, avg_torque, exp_t);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[8];
        rst = 1'b1;
        RX  = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_batt", batt_v, 12'h000);
        chk("rst_curr", avg_curr, 12'h000);
        chk("rst_torq", avg_torque, 12'h000);
        chk("rst_vld", vld, 1'b0);
        chk("rst_err", frm_err, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // clean frame; vld must already have fired by the end of the last stop bit
        fr = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h07, 8'hFF};
        for (int i = 0; i < 8; i++) send_byte(fr[i]);
        chk("clean_latency", n_vld, 1);
        settle_check("clean");
        chk("clean_batt_lit", batt_v, 12'hABC);
        chk("clean_torq_lit", avg_torque, 12'h7FF);

        // resync
        begin
            logic [7:0] rs[10];
            rs = '{8'h13, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30};
            for (int i = 0; i < 10; i++) send_byte(rs[i]);
        end
        settle_check("resync");
        chk("resync_curr_lit", avg_curr, 12'h020);

        // bad high byte
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h1A);
        chk("badhi_latency", n_err, exp_err);
        send_byte(8'hBC); send_byte(8'h01); send_byte(8'h23); send_byte(8'h07); send_byte(8'hFF);
        settle_check("badhi");

        // stall after 3 payload bytes, then a clean frame
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03); send_byte(8'h44); send_byte(8'h05);
        stall();
        settle_check("stall");
        tx_frame(12'h321, 12'h654, 12'h987);
        settle_check("post_stall");

        // reset after 4th payload byte
        send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'h0F); send_byte(8'hEE); send_byte(8'h0D); send_byte(8'hCC);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        chk("midrst_batt", batt_v, 12'h000);
        chk("midrst_torq", avg_torque, 12'h000);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        settle_check("midrst");
        tx_frame(12'h5A5, 12'h0F0, 12'hC3C);
        settle_check("post_rst");

        // loopback-style frame
        tx_frame(12'h800, 12'h456, 12'hFFF);
        settle_check("loop");

        // randomized traffic
        for (int k = 0; k < 22; k++) begin
            case ($urandom_range(0, 3))
                0, 1: tx_frame(12'($urandom), 12'($urandom), 12'($urandom));
                2: begin
                    int n;
                    n = $urandom_range(1, 4);
                    for (int j = 0; j < n; j++) send_byte(8'($urandom));
                end
                default: begin
                    int pos;
                    pos = 2 * $urandom_range(0, 2);
                    send_byte(8'hAA); send_byte(8'h55);
                    for (int j = 0; j < 6; j++) begin
                        if (j == pos) send_byte(8'($urandom_range(16, 255)));
                        else          send_byte(8'($urandom_range(0, 15)));
                    end
                end
            endcase
            if ($urandom_range(0, 5) == 0) stall();
            settle_check($sformatf("rnd%0d", k));
        end

        chk("out_stable", n_unstable, 0);
        chk("vld_err_overlap", n_overlap, 0);
        chk("pulse_width", n_wide, 0);
        chk("last_got_batt", got_b, exp_b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
